ladder_sprite_engine: RTL and testbench

// Parametrised multi-ladder sprite renderer for the VGA pixel path. It holds up to NUM_LADDERS ladder objects
// (x, y, length, enable) and tiles a TILE_H-row pattern vertically over each ladder's length.
// For every scanned pixel it reports whether a ladder covers it and which one, with fixed 2-cycle latency.

---
 rtl/ladder_sprite_engine_pkg.sv | 36 +++
 rtl/ladder_sprite_engine_if.sv | 33 +++
 rtl/ladder_sprite_engine_hit_unit.sv | 45 ++++
 rtl/ladder_sprite_engine.sv | 138 +++++++++++++
 tb/tb_ladder_sprite_engine.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladder_sprite_engine_pkg.sv
// rtl/ladder_sprite_engine_pkg.sv - shared widths, config record and default ladder pattern
package ladder_pkg;

  localparam int SPRITE_W    = 14;
  localparam int TILE_H      = 7;
  localparam int NUM_LADDERS = 4;
  localparam int X_W         = 10;
  localparam int Y_W         = 10;
  localparam int LEN_W       = 8;

  // Width of an index/counter that must hold 0..n-1, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = clog2_min1(NUM_LADDERS);

  // Column 0 is the MSB (leftmost pixel); rails occupy cols 0-1 and 12-13
  localparam logic [SPRITE_W-1:0] LADDER_RAIL = 14'h3003;
  localparam logic [SPRITE_W-1:0] LADDER_RUNG = 14'h3FFF;

  // Row 0 is the ladder's top row; rows 3-4 of each period carry the rung
  localparam logic [0:TILE_H-1][SPRITE_W-1:0] LADDER_TILE = {
    LADDER_RAIL, LADDER_RAIL, LADDER_RAIL,
    LADDER_RUNG, LADDER_RUNG,
    LADDER_RAIL, LADDER_RAIL
  };

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [LEN_W-1:0] len;
    logic             en;
  } ladder_cfg_t;

endpackage

// File: rtl/ladder_sprite_engine_if.sv
// rtl/ladder_sprite_engine_if.sv - config write port, pixel scan input and pixel result output
interface ladder_sprite_engine_if #(
  parameter int IDX_W = 2,
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int LEN_W = 8
);
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [X_W-1:0]   cfg_x;
  logic [Y_W-1:0]   cfg_y;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_en;
  logic             frame_start;
  logic             pix_valid;
  logic [X_W-1:0]   DrawX;
  logic [Y_W-1:0]   DrawY;
  logic             px_valid;
  logic             px_on;
  logic [IDX_W-1:0] px_idx;

  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_len, cfg_en, frame_start,
    output pix_valid, DrawX, DrawY,
    input  px_valid, px_on, px_idx
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_len, cfg_en, frame_start,
    input  pix_valid, DrawX, DrawY,
    output px_valid, px_on, px_idx
  );
endinterface

// File: rtl/ladder_sprite_engine_hit_unit.sv
// rtl/ladder_sprite_engine_hit_unit.sv - one ladder's bounding-box test and local row/column
module ladder_hit_unit
  import ladder_pkg::*;
#(
  parameter int SPRITE_W = 14,
  parameter int TILE_H   = 7,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int LEN_W    = 8,
  parameter int ROW_W    = clog2_min1(TILE_H),
  parameter int COL_W    = clog2_min1(SPRITE_W)
) (
  input  logic             i_pix_valid,
  input  logic [X_W-1:0]   i_draw_x,
  input  logic [Y_W-1:0]   i_draw_y,
  input  logic [X_W-1:0]   i_x,
  input  logic [Y_W-1:0]   i_y,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_en,
  output logic             o_inbox,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  // One extra bit on the far edges so ladders hanging off the screen clip instead of wrapping
  localparam int YS_W = ((Y_W > LEN_W) ? Y_W : LEN_W) + 1;

  logic [X_W:0]    w_x_end;
  logic [YS_W-1:0] w_y_end;
  logic            w_in_x;
  logic            w_in_y;
  logic [Y_W-1:0]  w_dy;

  assign w_x_end = {1'b0, i_x} + (X_W+1)'(SPRITE_W);
  assign w_y_end = YS_W'(i_y) + YS_W'(i_len);
  assign w_in_x  = (i_draw_x >= i_x) && ({1'b0, i_draw_x} < w_x_end);
  assign w_in_y  = (i_draw_y >= i_y) && (YS_W'(i_draw_y) < w_y_end);
  assign o_inbox = i_pix_valid && i_en && (i_len != '0) && w_in_x && w_in_y;

  // Pattern phase is anchored at the ladder's own top row
  assign w_dy  = i_draw_y - i_y;
  assign o_row = ROW_W'(w_dy % Y_W'(TILE_H));
  assign o_col = COL_W'(i_draw_x - i_x);

endmodule

// File: rtl/ladder_sprite_engine.sv
// rtl/ladder_sprite_engine.sv - double-buffered multi-ladder sprite renderer, 2-cycle pixel pipeline
module ladder_sprite_engine
  import ladder_pkg::*;
#(
  parameter int SPRITE_W    = ladder_pkg::SPRITE_W,
  parameter int TILE_H      = ladder_pkg::TILE_H,
  parameter logic [0:TILE_H-1][SPRITE_W-1:0] TILE = ladder_pkg::LADDER_TILE,
  parameter int NUM_LADDERS = ladder_pkg::NUM_LADDERS,
  parameter int X_W         = ladder_pkg::X_W,
  parameter int Y_W         = ladder_pkg::Y_W,
  parameter int LEN_W       = ladder_pkg::LEN_W,
  parameter int IDX_W       = clog2_min1(NUM_LADDERS)
) (
  input logic                    Clk,
  input logic                    Reset_n,
  ladder_sprite_engine_if.slave  bus
);

  localparam int ROW_W = clog2_min1(TILE_H);
  localparam int COL_W = clog2_min1(SPRITE_W);

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [LEN_W-1:0] len;
    logic             en;
  } cfg_t;

  cfg_t r_shadow [NUM_LADDERS];
  cfg_t r_active [NUM_LADDERS];

  logic [NUM_LADDERS-1:0] w_inbox;
  logic [ROW_W-1:0]       w_row [NUM_LADDERS];
  logic [COL_W-1:0]       w_col [NUM_LADDERS];

  logic [NUM_LADDERS-1:0] r_inbox;
  logic [ROW_W-1:0]       r_row [NUM_LADDERS];
  logic [COL_W-1:0]       r_col [NUM_LADDERS];
  logic                   r_pv;

  logic [NUM_LADDERS-1:0] w_bits;
  logic [IDX_W-1:0]       w_hit_idx;

  logic                   r_px_valid;
  logic                   r_px_on;
  logic [IDX_W-1:0]       r_px_idx;

  // Shadow takes writes; a commit copies the pre-write shadow, so a same-cycle write waits a frame
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LADDERS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (bus.frame_start) begin
        r_active <= r_shadow;
      end
      if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_LADDERS)) begin
        r_shadow[bus.cfg_idx] <= '{x: bus.cfg_x, y: bus.cfg_y, len: bus.cfg_len, en: bus.cfg_en};
      end
    end
  end

  for (genvar g = 0; g < NUM_LADDERS; g++) begin : g_hit
    ladder_hit_unit #(
      .SPRITE_W (SPRITE_W),
      .TILE_H   (TILE_H),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .LEN_W    (LEN_W),
      .ROW_W    (ROW_W),
      .COL_W    (COL_W)
    ) u_hit (
      .i_pix_valid (bus.pix_valid),
      .i_draw_x    (bus.DrawX),
      .i_draw_y    (bus.DrawY),
      .i_x         (r_active[g].x),
      .i_y         (r_active[g].y),
      .i_len       (r_active[g].len),
      .i_en        (r_active[g].en),
      .o_inbox     (w_inbox[g]),
      .o_row       (w_row[g]),
      .o_col       (w_col[g])
    );
  end

  // Stage 1: capture every ladder's box result and local coordinates
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_inbox <= '0;
      r_pv    <= 1'b0;
      for (int i = 0; i < NUM_LADDERS; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else begin
      r_inbox <= w_inbox;
      r_pv    <= bus.pix_valid;
      r_row   <= w_row;
      r_col   <= w_col;
    end
  end

  // Stage 2 lookup: pattern bit per ladder, then fixed priority with index 0 winning
  always_comb begin
    w_bits    = '0;
    w_hit_idx = '0;
    for (int i = 0; i < NUM_LADDERS; i++) begin
      if (r_inbox[i]) begin
        w_bits[i] = TILE[r_row[i]][SPRITE_W-1-int'(r_col[i])];
      end
    end
    for (int i = NUM_LADDERS-1; i >= 0; i--) begin
      if (w_bits[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  // Stage 2 output registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_px_valid <= 1'b0;
      r_px_on    <= 1'b0;
      r_px_idx   <= '0;
    end else begin
      r_px_valid <= r_pv;
      r_px_on    <= |w_bits;
      r_px_idx   <= w_hit_idx;
    end
  end

  assign bus.px_valid = r_px_valid;
  assign bus.px_on    = r_px_on;
  assign bus.px_idx   = r_px_idx;

endmodule

// File: tb/tb_ladder_sprite_engine.sv
// tb/tb_ladder_sprite_engine.sv - directed self-checking bench for ladder_sprite_engine
module tb_ladder_sprite_engine;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ladder_sprite_engine_if #(.IDX_W(2), .X_W(10), .Y_W(10), .LEN_W(8)) bus ();

  ladder_sprite_engine dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_pix(input bit v, input int x, input int y);
    bus.pix_valid = v;
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
  endtask

  task automatic write_cfg(input int idx, input int x, input int y, input int len,
                           input bit en, input bit fs);
    @(negedge clk);
    bus.cfg_we      = 1'b1;
    bus.cfg_idx     = 2'(idx);
    bus.cfg_x       = 10'(x);
    bus.cfg_y       = 10'(y);
    bus.cfg_len     = 8'(len);
    bus.cfg_en      = en;
    bus.frame_start = fs;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // Single isolated pixel; returns the outputs two clocks after it was presented
  task automatic probe(input int x, input int y, output logic v, output logic on,
                       output logic [1:0] idx);
    @(negedge clk);
    drive_pix(1'b1, x, y);
    @(negedge clk);
    drive_pix(1'b0, 0, 0);
    @(negedge clk);
    v   = bus.px_valid;
    on  = bus.px_on;
    idx = bus.px_idx;
  endtask

  task automatic test_reset();
    logic v, on;
    logic [1:0] idx;
    rst_n = 1'b0;
    drive_pix(1'b1, 100, 53);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.px_valid, bus.px_on, bus.px_idx} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b on=%0b idx=%0d want 0 0 0",
               bus.px_valid, bus.px_on, bus.px_idx);
    end
    drive_pix(1'b0, 0, 0);
    rst_n = 1'b1;
    write_cfg(0, 100, 50, 20, 1'b1, 1'b0);
    probe(100, 53, v, on, idx);
    total++;
    if (v !== 1'b1 || on !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_commit: got v=%0b on=%0b want v=1 on=0", v, on);
    end
  endtask

  task automatic test_single();
    logic v, on;
    logic [1:0] idx;
    int tx[8];
    int ty[8];
    bit te[8];
    commit();
    // Row 53 is local row 3 (rung): all 14 columns lit, output lags input by two clocks
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        total++;
        if (bus.px_valid !== ((n >= 2 && n <= 15) ? 1'b1 : 1'b0) ||
            bus.px_on    !== ((n >= 2 && n <= 15) ? 1'b1 : 1'b0) ||
            bus.px_idx   !== 2'd0) begin
          bad++;
          $display("FAIL scan_rung n=%0d: got v=%0b on=%0b idx=%0d want v=on=%0b idx=0",
                   n, bus.px_valid, bus.px_on, bus.px_idx, (n >= 2 && n <= 15));
        end
      end
      if (n < 14) drive_pix(1'b1, 100 + n, 53);
      else        drive_pix(1'b0, 0, 0);
    end
    tx = '{102, 101, 114, 100, 100, 105,  99, 113};
    ty = '{ 55,  55,  53,  70,  69,  60,  53,  55};
    te = '{  0,   1,   0,   0,   1,   1,   0,   1};
    for (int k = 0; k < 8; k++) begin
      probe(tx[k], ty[k], v, on, idx);
      total++;
      if (v !== 1'b1 || on !== te[k] || idx !== 2'd0) begin
        bad++;
        $display("FAIL single_pt(%0d,%0d): got v=%0b on=%0b idx=%0d want v=1 on=%0b idx=0",
                 tx[k], ty[k], v, on, idx, te[k]);
      end
    end
  endtask

  task automatic test_double_buffer();
    logic v, on;
    logic [1:0] idx;
    write_cfg(1, 300, 50, 20, 1'b1, 1'b1);
    probe(300, 53, v, on, idx);
    total++;
    if (on !== 1'b0) begin
      bad++;
      $display("FAIL dbuf_same_cycle: got on=%0b want 0", on);
    end
    commit();
    probe(300, 53, v, on, idx);
    total++;
    if (on !== 1'b1 || idx !== 2'd1) begin
      bad++;
      $display("FAIL dbuf_next_frame: got on=%0b idx=%0d want on=1 idx=1", on, idx);
    end
    probe(100, 53, v, on, idx);
    total++;
    if (on !== 1'b1 || idx !== 2'd0) begin
      bad++;
      $display("FAIL dbuf_idx0_kept: got on=%0b idx=%0d want on=1 idx=0", on, idx);
    end
  endtask

  task automatic test_overlap();
    logic v, on;
    logic [1:0] idx;
    write_cfg(0, 200, 97, 10, 1'b1, 1'b0);
    write_cfg(2, 190, 96, 10, 1'b1, 1'b0);
    commit();
    probe(200, 100, v, on, idx);
    total++;
    if (on !== 1'b1 || idx !== 2'd0) begin
      bad++;
      $display("FAIL overlap_pri: got on=%0b idx=%0d want on=1 idx=0", on, idx);
    end
    probe(203, 101, v, on, idx);
    total++;
    if (on !== 1'b1 || idx !== 2'd0) begin
      bad++;
      $display("FAIL overlap_both: got on=%0b idx=%0d want on=1 idx=0", on, idx);
    end
    write_cfg(0, 200, 97, 10, 1'b0, 1'b0);
    commit();
    probe(200, 100, v, on, idx);
    total++;
    if (on !== 1'b1 || idx !== 2'd2) begin
      bad++;
      $display("FAIL overlap_idx2: got on=%0b idx=%0d want on=1 idx=2", on, idx);
    end
    probe(201, 101, v, on, idx);
    total++;
    if (on !== 1'b0 || idx !== 2'd0) begin
      bad++;
      $display("FAIL overlap_gap: got on=%0b idx=%0d want on=0 idx=0", on, idx);
    end
  endtask

  task automatic test_edge_clip();
    logic v, on;
    logic [1:0] idx;
    int tx[7];
    int ty[7];
    bit te[7];
    write_cfg(3, 1020, 1015, 255, 1'b1, 1'b0);
    commit();
    tx = '{1020, 1021, 1023, 1023,    3, 1020,    0};
    ty = '{1015, 1023, 1018, 1015, 1018,    3, 1018};
    te = '{   1,    1,    1,    0,    0,    0,    0};
    for (int k = 0; k < 7; k++) begin
      probe(tx[k], ty[k], v, on, idx);
      total++;
      if (on !== te[k] || idx !== (te[k] ? 2'd3 : 2'd0)) begin
        bad++;
        $display("FAIL edge_clip(%0d,%0d): got on=%0b idx=%0d want on=%0b",
                 tx[k], ty[k], on, idx, te[k]);
      end
    end
  endtask

  task automatic test_disabled();
    logic v, on;
    logic [1:0] idx;
    write_cfg(3, 1020, 1015, 0, 1'b1, 1'b0);
    write_cfg(2, 190, 96, 10, 1'b0, 1'b0);
    commit();
    probe(1020, 1015, v, on, idx);
    total++;
    if (on !== 1'b0) begin
      bad++;
      $display("FAIL len_zero: got on=%0b want 0", on);
    end
    probe(200, 100, v, on, idx);
    total++;
    if (on !== 1'b0) begin
      bad++;
      $display("FAIL en_zero: got on=%0b want 0", on);
    end
  endtask

  task automatic test_back_to_back();
    bit pat[8];
    bit e;
    pat = '{1, 1, 0, 1, 0, 0, 1, 1};
    // Coordinate stays on a lit pixel of ladder 1, so px_on must follow pix_valid too
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        e = (n >= 2 && n <= 9) ? pat[n-2] : 1'b0;
        total++;
        if (bus.px_valid !== e || bus.px_on !== e) begin
          bad++;
          $display("FAIL stream n=%0d: got v=%0b on=%0b want %0b", n, bus.px_valid, bus.px_on, e);
        end
      end
      if (n < 8) drive_pix(pat[n], 300, 53);
      else       drive_pix(1'b0, 300, 53);
    end
  endtask

  task automatic test_reset_flush();
    logic v, on;
    logic [1:0] idx;
    @(negedge clk);
    drive_pix(1'b1, 300, 53);
    @(negedge clk);
    drive_pix(1'b0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.px_valid, bus.px_on, bus.px_idx} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flush: got v=%0b on=%0b idx=%0d want 0 0 0",
               bus.px_valid, bus.px_on, bus.px_idx);
    end
    rst_n = 1'b1;
    probe(300, 53, v, on, idx);
    total++;
    if (v !== 1'b1 || on !== 1'b0) begin
      bad++;
      $display("FAIL reset_clears_active: got v=%0b on=%0b want v=1 on=0", v, on);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_idx     = '0;
    bus.cfg_x       = '0;
    bus.cfg_y       = '0;
    bus.cfg_len     = '0;
    bus.cfg_en      = 1'b0;
    bus.frame_start = 1'b0;
    drive_pix(1'b0, 0, 0);
    test_reset();
    test_single();
    test_double_buffer();
    test_overlap();
    test_edge_clip();
    test_disabled();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
